// File: rtl/clk_gate_bank_pkg.sv
// Shared definitions for the clock-gate bank: the channel FSM state encoding
// and the default parameter values.
package clk_gate_bank_pkg;

    // Per-channel gating FSM states
    typedef enum logic [1:0] {
        CG_OFF  = 2'd0,
        CG_WAKE = 2'd1,
        CG_ON   = 2'd2,
        CG_IDLE = 2'd3
    } cg_state_e;

    localparam int unsigned NCH_DEF      = 4;
    localparam int unsigned CNT_W_DEF    = 8;
    localparam int unsigned WAKE_CYC_DEF = 2;

    // Wake counter width; holds WAKE_CYC-1 for WAKE_CYC up to 15
    localparam int unsigned WAKE_W = 4;

endpackage : clk_gate_bank_pkg

// File: rtl/icg_cell.sv
// Integrated clock-gating cell: latch transparent while CK is low, AND gate
// on the output, so the enable can only change while the clock is low and
// every GCK pulse is a whole CK high phase.
//   CK  : source clock
//   E   : functional enable
//   SE  : scan enable, forces the gate open
//   GCK : gated clock
module icg_cell (
    input  logic CK,
    input  logic E,
    input  logic SE,
    output logic GCK
);

    logic en_lat;

    // Enable latch, closed during the CK high phase
    always_latch begin
        if (!CK) begin
            en_lat <= E | SE;
        end
    end

    assign GCK = CK & en_lat;

endmodule : icg_cell

// File: rtl/clk_gate_bank.sv
// Bank of NCH independently gated clocks. Each channel runs its own
// OFF/WAKE/ON/IDLE FSM that raises the functional enable on request, reports
// ready after a fixed wake time, and auto-gates after idle_limit idle cycles.
//   CK, RN     : source clock, synchronous active-low reset
//   SE         : scan enable, opens every gate without touching the FSMs
//   req        : per-channel clock request
//   busy       : per-channel activity, keeps the clock on
//   force_off  : per-channel immediate shutdown (highest priority)
//   idle_limit : idle cycles tolerated before gating
//   gck        : gated clocks
//   ready      : gated clock running and stable (ON or IDLE)
//   gated      : functional enable currently low
module clk_gate_bank
    import clk_gate_bank_pkg::*;
#(
    parameter int unsigned NCH      = NCH_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned WAKE_CYC = WAKE_CYC_DEF
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             SE,
    input  logic [NCH-1:0]   req,
    input  logic [NCH-1:0]   busy,
    input  logic [NCH-1:0]   force_off,
    input  logic [CNT_W-1:0] idle_limit,
    output logic [NCH-1:0]   gck,
    output logic [NCH-1:0]   ready,
    output logic [NCH-1:0]   gated
);

    localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYC - 1);

    for (genvar i = 0; i < NCH; i++) begin : g_ch

        cg_state_e          state_q;
        logic               en_q;
        logic               ready_q;
        logic [CNT_W-1:0]   cnt_q;
        logic [WAKE_W-1:0]  wake_q;

        // Channel FSM; en_q and ready_q are registered alongside the state
        always_ff @(posedge CK) begin
            if (!RN) begin
                state_q <= CG_OFF;
                en_q    <= 1'b0;
                ready_q <= 1'b0;
                cnt_q   <= '0;
                wake_q  <= '0;
            end else if (force_off[i]) begin
                state_q <= CG_OFF;
                en_q    <= 1'b0;
                ready_q <= 1'b0;
                cnt_q   <= '0;
                wake_q  <= '0;
            end else begin
                case (state_q)
                    CG_OFF: begin
                        if (req[i]) begin
                            state_q <= CG_WAKE;
                            en_q    <= 1'b1;
                            wake_q  <= WAKE_LOAD;
                        end
                    end
                    CG_WAKE: begin
                        // Wake always runs to completion, even if req drops
                        if (wake_q == '0) begin
                            state_q <= CG_ON;
                            ready_q <= 1'b1;
                        end else begin
                            wake_q <= wake_q - WAKE_W'(1);
                        end
                    end
                    CG_ON: begin
                        if (!req[i] && !busy[i]) begin
                            if (idle_limit == '0) begin
                                // Zero tolerance: gate immediately
                                state_q <= CG_OFF;
                                en_q    <= 1'b0;
                                ready_q <= 1'b0;
                            end else begin
                                state_q <= CG_IDLE;
                                cnt_q   <= idle_limit;
                            end
                        end
                    end
                    CG_IDLE: begin
                        if (req[i] || busy[i]) begin
                            state_q <= CG_ON;
                        end else if (cnt_q == '0) begin
                            state_q <= CG_OFF;
                            en_q    <= 1'b0;
                            ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= CG_OFF;
                        en_q    <= 1'b0;
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end

        icg_cell u_icg (
            .CK  (CK),
            .E   (en_q),
            .SE  (SE),
            .GCK (gck[i])
        );

        assign ready[i] = ready_q;
        assign gated[i] = ~en_q;

    end : g_ch

endmodule : clk_gate_bank

// File: tb/tb_clk_gate_bank.sv
// Directed-vector bench for clk_gate_bank with a scoreboard queue. Each vector
// is applied just after a rising edge; its expected ready/gated after the next
// rising edge, and the gck level during that edge's high phase, are queued and
// checked by an independent monitor. gck must also be low in every low phase.
module tb_clk_gate_bank;

    logic       CK;
    logic       RN;
    logic       SE;
    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] force_off;
    logic [7:0] idle_limit;
    logic [3:0] gck;
    logic [3:0] ready;
    logic [3:0] gated;

    clk_gate_bank #(
        .NCH      (4),
        .CNT_W    (8),
        .WAKE_CYC (2)
    ) dut (
        .CK         (CK),
        .RN         (RN),
        .SE         (SE),
        .req        (req),
        .busy       (busy),
        .force_off  (force_off),
        .idle_limit (idle_limit),
        .gck        (gck),
        .ready      (ready),
        .gated      (gated)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    typedef struct packed {
        logic       rn;
        logic       se;
        logic [3:0] req;
        logic [3:0] busy;
        logic [3:0] foff;
        logic [7:0] lim;
        logic [3:0] ready;
        logic [3:0] gated;
        logic [3:0] gck;
    } vec_t;

    typedef struct packed {
        logic [7:0] idx;
        logic [3:0] ready;
        logic [3:0] gated;
        logic [3:0] gck;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    int applied     = 0;
    int miscompares = 0;

    function automatic void v(input logic rn, input logic se, input logic [3:0] rq,
                              input logic [3:0] bz, input logic [3:0] fo,
                              input logic [7:0] lim, input logic [3:0] rdy,
                              input logic [3:0] gtd, input logic [3:0] gk);
        vec_t t;
        t = '{rn: rn, se: se, req: rq, busy: bz, foff: fo, lim: lim,
              ready: rdy, gated: gtd, gck: gk};
        vecs.push_back(t);
    endfunction

    // Monitor: snapshot queue depth at the edge (before the next vector is
    // pushed), sample gck in the high phase, then compare in the low phase.
    initial begin : monitor
        int         n;
        logic [3:0] gck_hi;
        exp_t       e;
        forever begin
            @(posedge CK);
            n = exp_q.size();
            #2 gck_hi = gck;
            @(negedge CK);
            #1;
            if (n > 0) begin
                e = exp_q.pop_front();
                applied++;
                if ({ready, gated, gck_hi} !== {e.ready, e.gated, e.gck} || gck !== 4'h0) begin
                    miscompares++;
                    $display("FAIL vec%0d: ready=%h gated=%h gck_hi=%h gck_lo=%h, expected ready=%h gated=%h gck_hi=%h gck_lo=0",
                             e.idx, ready, gated, gck_hi, gck, e.ready, e.gated, e.gck);
                end
            end
        end
    end

    initial begin : stimulus
        exp_t e;
        RN = 1'b0; SE = 1'b0; req = '0; busy = '0; force_off = '0; idle_limit = '0;

        //  rn se req busy foff lim   ready gated gck
        // reset held with every request asserted
        v(0, 0, 4'hF, 4'h0, 4'h0, 8'd5, 4'h0, 4'hF, 4'h0);
        v(0, 0, 4'hF, 4'h0, 4'h0, 8'd5, 4'h0, 4'hF, 4'h0);
        v(0, 0, 4'hF, 4'h0, 4'h0, 8'd5, 4'h0, 4'hF, 4'h0);
        // release: WAKE, first pulse next cycle, ready two edges later
        v(1, 0, 4'hF, 4'h0, 4'h0, 8'd5, 4'h0, 4'h0, 4'h0);
        v(1, 0, 4'hF, 4'h0, 4'h0, 8'd5, 4'h0, 4'h0, 4'hF);
        v(1, 0, 4'hF, 4'h0, 4'h0, 8'd5, 4'hF, 4'h0, 4'hF);
        // ch0 idles (limit 5), busy pulse at count 2 returns it to ON
        v(1, 0, 4'hE, 4'h0, 4'h0, 8'd5, 4'hF, 4'h0, 4'hF);
        v(1, 0, 4'hE, 4'h0, 4'h0, 8'd5, 4'hF, 4'h0, 4'hF);
        v(1, 0, 4'hE, 4'h0, 4'h0, 8'd5, 4'hF, 4'h0, 4'hF);
        v(1, 0, 4'hE, 4'h0, 4'h0, 8'd5, 4'hF, 4'h0, 4'hF);
        v(1, 0, 4'hE, 4'h1, 4'h0, 8'd5, 4'hF, 4'h0, 4'hF);
        // ch0 idles again: six more pulses after entering IDLE, then OFF
        v(1, 0, 4'hE, 4'h0, 4'h0, 8'd5, 4'hF, 4'h0, 4'hF);
        v(1, 0, 4'hE, 4'h0, 4'h0, 8'd5, 4'hF, 4'h0, 4'hF);
        v(1, 0, 4'hE, 4'h0, 4'h0, 8'd5, 4'hF, 4'h0, 4'hF);
        v(1, 0, 4'hE, 4'h0, 4'h0, 8'd5, 4'hF, 4'h0, 4'hF);
        v(1, 0, 4'hE, 4'h0, 4'h0, 8'd5, 4'hF, 4'h0, 4'hF);
        v(1, 0, 4'hE, 4'h0, 4'h0, 8'd5, 4'hF, 4'h0, 4'hF);
        v(1, 0, 4'hE, 4'h0, 4'h0, 8'd5, 4'hE, 4'h1, 4'hF);
        v(1, 0, 4'hE, 4'h0, 4'h0, 8'd5, 4'hE, 4'h1, 4'hE);
        // ch1 with limit 0: straight to OFF, one final pulse
        v(1, 0, 4'hC, 4'h0, 4'h0, 8'd0, 4'hC, 4'h3, 4'hE);
        v(1, 0, 4'hC, 4'h0, 4'h0, 8'd0, 4'hC, 4'h3, 4'hC);
        // ch2 into IDLE, then force_off with req asserted
        v(1, 0, 4'h8, 4'h0, 4'h0, 8'd5, 4'hC, 4'h3, 4'hC);
        v(1, 0, 4'hC, 4'h0, 4'h4, 8'd5, 4'h8, 4'h7, 4'hC);
        v(1, 0, 4'h8, 4'h0, 4'h0, 8'd5, 4'h8, 4'h7, 4'h8);
        // force_off beats req and busy on ch3 in ON
        v(1, 0, 4'h8, 4'h8, 4'h8, 8'd5, 4'h0, 4'hF, 4'h8);
        v(1, 0, 4'h0, 4'h0, 4'h0, 8'd5, 4'h0, 4'hF, 4'h0);
        // scan enable with everything OFF
        v(1, 1, 4'h0, 4'h0, 4'h0, 8'd5, 4'h0, 4'hF, 4'hF);
        v(1, 1, 4'h0, 4'h0, 4'h0, 8'd5, 4'h0, 4'hF, 4'hF);
        v(1, 0, 4'h0, 4'h0, 4'h0, 8'd5, 4'h0, 4'hF, 4'h0);
        // reset aborts ON on ch0 after a whole pulse
        v(1, 0, 4'h1, 4'h0, 4'h0, 8'd5, 4'h0, 4'hE, 4'h0);
        v(1, 0, 4'h1, 4'h0, 4'h0, 8'd5, 4'h0, 4'hE, 4'h1);
        v(1, 0, 4'h1, 4'h0, 4'h0, 8'd5, 4'h1, 4'hE, 4'h1);
        v(0, 0, 4'h1, 4'h0, 4'h0, 8'd5, 4'h0, 4'hF, 4'h1);
        v(0, 0, 4'h1, 4'h0, 4'h0, 8'd5, 4'h0, 4'hF, 4'h0);
        // request taken on first edge out of reset, then forced off in WAKE
        v(1, 0, 4'h1, 4'h0, 4'h0, 8'd5, 4'h0, 4'hE, 4'h0);
        v(1, 0, 4'h1, 4'h0, 4'h1, 8'd5, 4'h0, 4'hF, 4'h1);
        v(1, 0, 4'h0, 4'h0, 4'h0, 8'd5, 4'h0, 4'hF, 4'h0);
        // req dropped during WAKE: wake completes, then ON gates with limit 0
        v(1, 0, 4'h1, 4'h0, 4'h0, 8'd5, 4'h0, 4'hE, 4'h0);
        v(1, 0, 4'h0, 4'h0, 4'h0, 8'd5, 4'h0, 4'hE, 4'h1);
        v(1, 0, 4'h0, 4'h0, 4'h0, 8'd5, 4'h1, 4'hE, 4'h1);
        v(1, 0, 4'h0, 4'h0, 4'h0, 8'd0, 4'h0, 4'hF, 4'h1);
        v(1, 0, 4'h0, 4'h0, 4'h0, 8'd0, 4'h0, 4'hF, 4'h0);

        // unchecked settling edges in reset
        repeat (2) @(posedge CK);

        foreach (vecs[k]) begin
            @(posedge CK);
            #1;
            RN         = vecs[k].rn;
            SE         = vecs[k].se;
            req        = vecs[k].req;
            busy       = vecs[k].busy;
            force_off  = vecs[k].foff;
            idle_limit = vecs[k].lim;
            e = '{idx: 8'(k + 1), ready: vecs[k].ready, gated: vecs[k].gated, gck: vecs[k].gck};
            exp_q.push_back(e);
        end

        repeat (3) @(posedge CK);
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule : tb_clk_gate_bank

// File: doc/clk_gate_bank.md
CLK_GATE_BANK -- requirements
Module: clk_gate_bank

Interface
REQ-001 Parameter NCH, default 4, number of independently gated clock channels (1..32).
REQ-002 Parameter CNT_W, default 8, width of idle countdown counter and idle_limit.
REQ-003 Parameter WAKE_CYC, default 2, gated-clock cycles between enable and ready (1..15).
REQ-004 CK  input  1  free-running source clock; all state updates on rising edge.
REQ-005 RN  input  1  reset, synchronous, active-low.
REQ-006 SE  input  1  scan/test enable; high forces every gck to follow CK.
REQ-007 req  input  NCH  per-channel functional clock request.
REQ-008 busy  input  NCH  per-channel activity indication; holds clock on while high.
REQ-009 force_off  input  NCH  per-channel immediate shutdown request.
REQ-010 idle_limit  input  CNT_W  idle cycles tolerated before auto-gating.
REQ-011 gck  output  NCH  gated clock per channel.
REQ-012 ready  output  NCH  per-channel: gated clock running and stable.
REQ-013 gated  output  NCH  per-channel: functional enable currently low.

Function
REQ-014 Each channel SHALL run an independent FSM with states OFF, WAKE, ON, IDLE.
REQ-015 OFF: en=0; req=1 -> WAKE next edge, en=1 from that edge.
REQ-016 WAKE: en=1; wake counter loaded with WAKE_CYC-1, decrements per edge; at 0 -> ON.
REQ-017 ON: en=1, ready=1; req=0 and busy=0 -> IDLE with counter loaded from idle_limit sampled that edge.
REQ-018 IDLE: en=1, ready=1; req|busy -> ON; otherwise decrement; counter 0 while idle -> OFF.
REQ-019 idle_limit=0: ON with req=0, busy=0 -> OFF directly next edge, bypassing IDLE.
REQ-020 force_off[i]=1 in any state -> OFF next edge; priority over req, busy, and counters.
REQ-021 req deassert during WAKE: WAKE SHALL complete, then ON/IDLE rules apply.
REQ-022 ready SHALL be registered; high exactly in ON and IDLE.
REQ-023 gated = ~en per channel.
REQ-024 Gating SHALL be glitch-free: enable (en|SE) captured by a latch transparent while CK low; gck = CK AND latched enable.
REQ-025 gck pulse count SHALL be whole CK high phases only; no truncated pulses.
REQ-026 SE=1: all gck follow CK from next CK low phase; FSMs, ready, gated unaffected.
REQ-027 Counters SHALL never wrap: decrement only when nonzero.

Reset
REQ-028 RN=0 at rising CK: all FSMs OFF, en=0, counters 0, ready=0, gated=all ones.
REQ-029 With RN=0 and SE=0, gck SHALL be 0 from the first CK low phase after the reset edge.
REQ-030 Reset mid-WAKE/ON/IDLE SHALL abort without a truncated gck pulse.
REQ-031 First request accepted on the first edge with RN=1.

Structure
REQ-032 Shared package: FSM state enum (OFF=0, WAKE=1, ON=2, IDLE=3) and default parameter constants.
REQ-033 One sub-module, icg_cell (CK, E, SE, GCK: latch + AND), instantiated NCH times.
REQ-034 Per-channel FSM/counters in a generate loop in clk_gate_bank; no cross-channel logic.

Verification
REQ-035 Reset: RN=0 three edges, req=all ones -> ready=0, gated=4'hF, gck=0; RN=1 -> WAKE next edge.
REQ-036 Wake: req[0] rises edge N, WAKE_CYC=2 -> gck[0] first pulse cycle N+1, ready[0]=1 after edge N+2.
REQ-037 Idle: idle_limit=5, req/busy drop in ON -> exactly 6 more gck pulses, then OFF, gated[0]=1; busy pulse at count 2 -> back to ON, no gating.
REQ-038 idle_limit=0: req drop in ON -> OFF next edge, one further gck pulse.
REQ-039 force_off[2]=1 with req[2]=1 in IDLE -> OFF next edge, ready[2]=0; channels 0,1,3 unchanged.
REQ-040 SE=1 while all OFF -> gck = CK on all channels, no glitches; SE=0 -> gck 0 from next low phase, FSM states unchanged.
